// File: rtl/resp_chk_pkg.sv
// Shared types, constants and MISR helpers for the response signature checker.
// The fold works on any bus up to FOLD_MAX_W bits; callers zero-extend their bus.
package resp_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] MISR_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] DEFAULT_SEED = 32'hFFFF_FFFF;
  localparam int          FOLD_MAX_W   = 1024;

  // Zero slices contribute nothing, so folding the zero-extended bus equals
  // folding ceil(WIDTH/32) slices with the top slice zero-extended.
  function automatic logic [31:0] misr_fold(input logic [FOLD_MAX_W-1:0] y);
    logic [31:0] f;
    f = 32'h0000_0000;
    for (int i = 0; i < FOLD_MAX_W / 32; i++) begin
      f = f ^ y[i*32 +: 32];
    end
    return f;
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                            input logic [31:0] folded);
    return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0000_0000) ^ folded;
  endfunction

endpackage

// File: rtl/resp_misr.sv
// 32-bit MISR compressing one WIDTH-bit bus per enabled clock.
// load reseeds the register; load has priority over en.
module resp_misr
  import resp_chk_pkg::*;
#(
  parameter int          WIDTH = 246,
  parameter logic [31:0] SEED  = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [31:0]      sig
);

  logic [31:0] sig_r;
  logic [31:0] fold_s;

  assign fold_s = misr_fold(FOLD_MAX_W'(data));

  // Signature register: seed on reset/load, shift-and-fold on each enabled sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_r <= SEED;
    end else if (load) begin
      sig_r <= SEED;
    end else if (en) begin
      sig_r <= misr_step(sig_r, fold_s);
    end else begin
      sig_r <= sig_r;
    end
  end

  assign sig = sig_r;

endmodule

// File: rtl/resp_sig_checker.sv
// Compares reference and DUT output buses over a fixed-length run, compressing
// both into MISR signatures and reporting mismatch count, first location and a verdict.
module resp_sig_checker
  import resp_chk_pkg::*;
#(
  parameter int          WIDTH       = 246,
  parameter int          NUM_SAMPLES = 22,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] SEED        = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             smp_valid,
  input  logic [WIDTH-1:0] y_ref,
  input  logic [WIDTH-1:0] y_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_mis_valid,
  output logic [CNT_W-1:0] first_mis_idx,
  output logic [CNT_W-1:0] smp_cnt,
  output logic [31:0]      sig_ref,
  output logic [31:0]      sig_dut
);

  state_e           state_r, state_nx_s;
  logic             accept_s, last_s, begin_s, finish_s, mis_s, sig_eq_nx_s;
  logic [CNT_W-1:0] smp_cnt_r, mis_cnt_r, first_idx_r;
  logic             first_valid_r, pass_r;

  assign accept_s = (state_r == ST_RUN) && smp_valid;
  assign last_s   = accept_s && (smp_cnt_r == CNT_W'(NUM_SAMPLES - 1));
  assign mis_s    = accept_s && (y_ref != y_dut);

  // The verdict must include the sample taken on the closing edge, so compare next signatures.
  assign sig_eq_nx_s = misr_step(sig_ref, misr_fold(FOLD_MAX_W'(y_ref))) ==
                       misr_step(sig_dut, misr_fold(FOLD_MAX_W'(y_dut)));

  // Next-state and run begin/finish decode; stop beats start in RUN, start beats stop in DONE.
  always_comb begin
    state_nx_s = state_r;
    begin_s    = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_RUN;
          begin_s    = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop || last_s) begin
          state_nx_s = ST_DONE;
          finish_s   = 1'b1;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nx_s = ST_RUN;
          begin_s    = 1'b1;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Sample counters and first-mismatch capture; cleared at the start of every run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt_r     <= {CNT_W{1'b0}};
      mis_cnt_r     <= {CNT_W{1'b0}};
      first_idx_r   <= {CNT_W{1'b0}};
      first_valid_r <= 1'b0;
    end else if (begin_s) begin
      smp_cnt_r     <= {CNT_W{1'b0}};
      mis_cnt_r     <= {CNT_W{1'b0}};
      first_idx_r   <= {CNT_W{1'b0}};
      first_valid_r <= 1'b0;
    end else if (accept_s) begin
      smp_cnt_r <= smp_cnt_r + CNT_W'(1);
      if (mis_s && (mis_cnt_r != {CNT_W{1'b1}})) begin
        mis_cnt_r <= mis_cnt_r + CNT_W'(1);
      end
      if (mis_s && !first_valid_r) begin
        first_idx_r   <= smp_cnt_r;
        first_valid_r <= 1'b1;
      end
    end
  end

  // Verdict latched on the edge that leaves RUN; an abort always fails.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_r <= 1'b0;
    end else if (begin_s) begin
      pass_r <= 1'b0;
    end else if (finish_s) begin
      pass_r <= !stop && (mis_cnt_r == {CNT_W{1'b0}}) && !mis_s && sig_eq_nx_s;
    end
  end

  resp_misr #(.WIDTH(WIDTH), .SEED(SEED)) u_misr_ref (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (begin_s),
    .en    (accept_s),
    .data  (y_ref),
    .sig   (sig_ref)
  );

  resp_misr #(.WIDTH(WIDTH), .SEED(SEED)) u_misr_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (begin_s),
    .en    (accept_s),
    .data  (y_dut),
    .sig   (sig_dut)
  );

  assign busy            = (state_r == ST_RUN);
  assign done            = (state_r == ST_DONE);
  assign pass            = pass_r;
  assign mismatch_cnt    = mis_cnt_r;
  assign first_mis_valid = first_valid_r;
  assign first_mis_idx   = first_idx_r;
  assign smp_cnt         = smp_cnt_r;

endmodule

// File: tb/tb_resp_sig_checker.sv
// Directed bench: a 32-bit/SEED=0 instance driven from a vector table with
// hand-computed signatures, plus hand sequences on the default 246-bit instance.
module tb_resp_sig_checker;

  localparam int          W    = 246;
  localparam int          N    = 22;
  localparam int          CW   = 16;
  localparam logic [31:0] SD   = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start, stop, smp_valid;
  logic [W-1:0]  y_ref, y_dut;
  logic          busy, done, pass, fmv;
  logic [CW-1:0] mis_cnt, fmi, smp_cnt;
  logic [31:0]   sig_ref, sig_dut;

  logic          s_start, s_stop, s_valid;
  logic [31:0]   s_y_ref, s_y_dut;
  logic          s_busy, s_done, s_pass, s_fmv;
  logic [CW-1:0] s_mis_cnt, s_fmi, s_smp_cnt;
  logic [31:0]   s_sig_ref, s_sig_dut;

  resp_sig_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .smp_valid(smp_valid),
    .y_ref(y_ref), .y_dut(y_dut), .busy(busy), .done(done), .pass(pass),
    .mismatch_cnt(mis_cnt), .first_mis_valid(fmv), .first_mis_idx(fmi),
    .smp_cnt(smp_cnt), .sig_ref(sig_ref), .sig_dut(sig_dut)
  );

  resp_sig_checker #(.WIDTH(32), .NUM_SAMPLES(4), .CNT_W(CW), .SEED(32'h0000_0000)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .stop(s_stop), .smp_valid(s_valid),
    .y_ref(s_y_ref), .y_dut(s_y_dut), .busy(s_busy), .done(s_done), .pass(s_pass),
    .mismatch_cnt(s_mis_cnt), .first_mis_valid(s_fmv), .first_mis_idx(s_fmi),
    .smp_cnt(s_smp_cnt), .sig_ref(s_sig_ref), .sig_dut(s_sig_dut)
  );

  typedef struct {
    logic        start, stop, valid;
    logic [31:0] yr, yd;
    logic        busy, done, pass;
    logic [15:0] mis, smp;
    logic [31:0] sr, sd;
    logic        fv;
    logic [15:0] fi;
  } vec_t;

  vec_t tbl[14];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Bit-serial reference: bit b of the bus lands on fold bit b%32.
  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [W-1:0] y);
    logic [31:0] f;
    logic [31:0] n;
    f = 32'h0;
    for (int b = 0; b < W; b++) f[b % 32] = f[b % 32] ^ y[b];
    n = {s[30:0], 1'b0};
    if (s[31]) n = n ^ POLY;
    return n ^ f;
  endfunction

  task automatic cyc(input logic st, input logic sp, input logic v,
                     input logic [W-1:0] r, input logic [W-1:0] d);
    start = st; stop = sp; smp_valid = v; y_ref = r; y_dut = d;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; smp_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_bus();
    logic [W-1:0] d;
    for (int j = 0; j < W; j++) d[j] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  task automatic chk_big_reset(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " pass"}, 32'(pass), 32'd0);
    chk({tag, " mis"}, 32'(mis_cnt), 32'd0);
    chk({tag, " fmv"}, 32'(fmv), 32'd0);
    chk({tag, " fmi"}, 32'(fmi), 32'd0);
    chk({tag, " smp"}, 32'(smp_cnt), 32'd0);
    chk({tag, " sig_ref"}, sig_ref, SD);
    chk({tag, " sig_dut"}, sig_dut, SD);
  endtask

  initial begin
    logic [31:0]  mr, md;
    logic [W-1:0] d, e;
    string        nm;

    //            st    sp    v     y_ref          y_dut          busy  done  pass  mis     smp     sig_ref        sig_dut        fv    fi
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 32'h0000_0000, 32'h0000_0000, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 16'd0, 16'd1, 32'h0000_0001, 32'h0000_0001, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 16'd0, 16'd2, 32'h0000_0002, 32'h0000_0002, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0001, 1'b1, 1'b0, 1'b0, 16'd1, 16'd3, 32'h8000_0004, 32'h8000_0005, 1'b1, 16'd2};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 16'd1, 16'd4, 32'h04C1_1DBF, 32'h04C1_1DBD, 1'b1, 16'd2};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b1, 1'b0, 16'd1, 16'd4, 32'h04C1_1DBF, 32'h04C1_1DBD, 1'b1, 16'd2};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 16'd1, 16'd4, 32'h04C1_1DBF, 32'h04C1_1DBD, 1'b1, 16'd2};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 32'h0000_0000, 32'h0000_0000, 1'b0, 16'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 16'd0, 16'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 16'd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 16'd0, 16'd2, 32'h04C1_1DB7, 32'h04C1_1DB7, 1'b0, 16'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 16'd0, 16'd3, 32'hF67D_C491, 32'hF67D_C491, 1'b0, 16'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 16'd0, 16'd4, 32'hE83A_9495, 32'hE83A_9495, 1'b0, 16'd0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 32'h0000_0000, 32'h0000_0000, 1'b0, 16'd0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 16'd0, 16'd1, 32'h0000_0001, 32'h0000_0001, 1'b0, 16'd0};

    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; smp_valid = 1'b0; y_ref = '0; y_dut = '0;
    s_start = 1'b0; s_stop = 1'b0; s_valid = 1'b0; s_y_ref = 32'h0; s_y_dut = 32'h0;
    @(posedge clk); #1;
    chk_big_reset("reset");
    chk("reset small sig", s_sig_ref, 32'h0000_0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Small instance: table of single-cycle vectors.
    for (int i = 0; i < 14; i++) begin
      s_start = tbl[i].start; s_stop = tbl[i].stop; s_valid = tbl[i].valid;
      s_y_ref = tbl[i].yr;    s_y_dut = tbl[i].yd;
      @(posedge clk); #1;
      nm = $sformatf("v%0d", i);
      chk({nm, " busy"}, 32'(s_busy), 32'(tbl[i].busy));
      chk({nm, " done"}, 32'(s_done), 32'(tbl[i].done));
      chk({nm, " pass"}, 32'(s_pass), 32'(tbl[i].pass));
      chk({nm, " mis"}, 32'(s_mis_cnt), 32'(tbl[i].mis));
      chk({nm, " smp"}, 32'(s_smp_cnt), 32'(tbl[i].smp));
      chk({nm, " sig_ref"}, s_sig_ref, tbl[i].sr);
      chk({nm, " sig_dut"}, s_sig_dut, tbl[i].sd);
      chk({nm, " fmv"}, 32'(s_fmv), 32'(tbl[i].fv));
      chk({nm, " fmi"}, 32'(s_fmi), 32'(tbl[i].fi));
    end
    s_start = 1'b0; s_stop = 1'b0; s_valid = 1'b0;

    // Full-length run with identical buses.
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    chk("run1 busy", 32'(busy), 32'd1);
    chk("run1 seed", sig_ref, SD);
    mr = SD;
    for (int k = 0; k < N; k++) begin
      d = rnd_bus();
      cyc(1'b0, 1'b0, 1'b1, d, d);
      mr = model_step(mr, d);
      if (k == N - 2) chk("run1 done early", 32'(done), 32'd0);
    end
    chk("run1 done", 32'(done), 32'd1);
    chk("run1 busy end", 32'(busy), 32'd0);
    chk("run1 pass", 32'(pass), 32'd1);
    chk("run1 smp", 32'(smp_cnt), 32'(N));
    chk("run1 sig_ref", sig_ref, mr);
    chk("run1 sig_dut", sig_dut, mr);
    chk("run1 mis", 32'(mis_cnt), 32'd0);
    d = rnd_bus();
    cyc(1'b0, 1'b0, 1'b1, d, ~d);
    chk("done hold smp", 32'(smp_cnt), 32'(N));
    chk("done hold sig", sig_ref, mr);
    chk("done hold mis", 32'(mis_cnt), 32'd0);

    // Restart from DONE; single-bit flip of the top bus bit on sample 5.
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    chk("run2 seed ref", sig_ref, SD);
    chk("run2 seed dut", sig_dut, SD);
    chk("run2 smp clr", 32'(smp_cnt), 32'd0);
    chk("run2 pass clr", 32'(pass), 32'd0);
    mr = SD; md = SD;
    for (int k = 0; k < N; k++) begin
      d = rnd_bus();
      e = d;
      if (k == 5) e[W-1] = ~e[W-1];
      cyc(1'b0, 1'b0, 1'b1, d, e);
      mr = model_step(mr, d);
      md = model_step(md, e);
      if (k == 4) chk("run2 fmv before", 32'(fmv), 32'd0);
    end
    chk("run2 done", 32'(done), 32'd1);
    chk("run2 pass", 32'(pass), 32'd0);
    chk("run2 fmv", 32'(fmv), 32'd1);
    chk("run2 fmi", 32'(fmi), 32'd5);
    chk("run2 mis", 32'(mis_cnt), 32'd1);
    chk("run2 sig_ref", sig_ref, mr);
    chk("run2 sig_dut", sig_dut, md);

    // Abort: stop coincides with the fourth sample.
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      d = rnd_bus();
      cyc(1'b0, 1'b0, 1'b1, d, d);
    end
    chk("abort busy before", 32'(busy), 32'd1);
    d = rnd_bus();
    cyc(1'b0, 1'b1, 1'b1, d, d);
    chk("abort smp", 32'(smp_cnt), 32'd4);
    chk("abort done", 32'(done), 32'd1);
    chk("abort pass", 32'(pass), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-run, then a fresh run counts from zero.
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 10; k++) begin
      d = rnd_bus();
      cyc(1'b0, 1'b0, 1'b1, d, (k == 2) ? ~d : d);
    end
    chk("midrun smp", 32'(smp_cnt), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk_big_reset("async rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_big_reset("post rst");
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    d = rnd_bus();
    cyc(1'b0, 1'b0, 1'b1, d, d);
    chk("rerun smp", 32'(smp_cnt), 32'd1);
    chk("rerun mis", 32'(mis_cnt), 32'd0);
    chk("rerun sig", sig_ref, model_step(SD, d));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
